// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port lane memory: lane count,
// sequencer states and the per-lane bit mask used when merging writes.
package mem_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 1024;
    localparam int unsigned MAX_LANES      = 1024;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int unsigned lanes_of(input int unsigned data_w, input int unsigned lane_w);
        return data_w / lane_w;
    endfunction

    // Expands one enable bit per lane into a bit mask covering that lane.
    function automatic logic [MAX_DATA_WIDTH-1:0] lane_mask(input logic [MAX_LANES-1:0] en,
                                                            input int unsigned lane_w,
                                                            input int unsigned lanes);
        logic [MAX_DATA_WIDTH-1:0] m;
        m = '0;
        for (int unsigned lane = 0; lane < lanes; lane++) begin
            for (int unsigned b = 0; b < lane_w; b++) begin
                m[lane * lane_w + b] = en[lane];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dual_port_lane_memory_if.sv
// Request/response bundle for both access ports of the lane memory.
interface dual_port_lane_memory_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 2
);
    logic                  ready;
    logic                  memoryWrite1;
    logic                  memoryWrite2;
    logic                  memoryRead1;
    logic                  memoryRead2;
    logic [ADDR_WIDTH-1:0] address1;
    logic [ADDR_WIDTH-1:0] address2;
    logic [LANES-1:0]      laneEnable1;
    logic [LANES-1:0]      laneEnable2;
    logic [DATA_WIDTH-1:0] writeData1;
    logic [DATA_WIDTH-1:0] writeData2;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic                  readValid1;
    logic                  readValid2;
    logic                  rangeError1;
    logic                  rangeError2;

    modport master (
        input  ready, readData1, readData2, readValid1, readValid2, rangeError1, rangeError2,
        output memoryWrite1, memoryWrite2, memoryRead1, memoryRead2,
               address1, address2, laneEnable1, laneEnable2, writeData1, writeData2
    );

    modport slave (
        output ready, readData1, readData2, readValid1, readValid2, rangeError1, rangeError2,
        input  memoryWrite1, memoryWrite2, memoryRead1, memoryRead2,
               address1, address2, laneEnable1, laneEnable2, writeData1, writeData2
    );
endinterface

// File: rtl/lane_merge.sv
// Combines an existing word with up to two lane-masked writes; port 2 owns
// any lane both ports enable.
module lane_merge
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANE_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]                         old_word_i,
    input  logic [DATA_WIDTH-1:0]                         wdata1_i,
    input  logic [DATA_WIDTH-1:0]                         wdata2_i,
    input  logic [lanes_of(DATA_WIDTH, LANE_WIDTH)-1:0]   en1_i,
    input  logic [lanes_of(DATA_WIDTH, LANE_WIDTH)-1:0]   en2_i,
    input  logic                                          hit1_i,
    input  logic                                          hit2_i,
    output logic [DATA_WIDTH-1:0]                         merged_c_o
);
    localparam int unsigned LANES = lanes_of(DATA_WIDTH, LANE_WIDTH);

    logic [DATA_WIDTH-1:0] mask1_c;
    logic [DATA_WIDTH-1:0] mask2_c;

    always_comb begin
        mask1_c = '0;
        mask2_c = '0;
        if (hit1_i) mask1_c = DATA_WIDTH'(lane_mask(MAX_LANES'(en1_i), LANE_WIDTH, LANES));
        if (hit2_i) mask2_c = DATA_WIDTH'(lane_mask(MAX_LANES'(en2_i), LANE_WIDTH, LANES));
        merged_c_o = (old_word_i & ~(mask1_c | mask2_c))
                   | (wdata1_i & mask1_c & ~mask2_c)
                   | (wdata2_i & mask2_c);
    end
endmodule

// File: rtl/dual_port_lane_memory.sv
// Two-port lane-enabled data memory with write-first forwarding, range
// checking and a post-reset zero-fill sequencer.
module dual_port_lane_memory
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LANE_WIDTH     = 16,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clock,
    input  logic                      resetN,
    dual_port_lane_memory_if.slave    bus
);
    localparam int unsigned LANES = lanes_of(DATA_WIDTH, LANE_WIDTH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam state_e      RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d;
    logic                  rvalid1_q, rvalid1_d, rvalid2_q, rvalid2_d;
    logic                  rerr1_q, rerr1_d, rerr2_q, rerr2_d;

    logic                  active_c;
    logic                  inr1_c, inr2_c, same_c;
    logic                  wr1_c, wr2_c;
    logic [IDX_W-1:0]      idx1_c, idx2_c;
    logic [DATA_WIDTH-1:0] post1_c, post2_c;

    assign active_c = (state_q == READY);
    assign inr1_c   = bus.address1 < ADDR_WIDTH'(DEPTH);
    assign inr2_c   = bus.address2 < ADDR_WIDTH'(DEPTH);
    assign same_c   = (bus.address1 == bus.address2);
    assign idx1_c   = IDX_W'(bus.address1);
    assign idx2_c   = IDX_W'(bus.address2);
    assign wr1_c    = active_c & bus.memoryWrite1 & inr1_c;
    assign wr2_c    = active_c & bus.memoryWrite2 & inr2_c;

    // Post-write word at each port's address; feeds both the array and the read path.
    lane_merge #(.DATA_WIDTH(DATA_WIDTH), .LANE_WIDTH(LANE_WIDTH)) u_merge1 (
        .old_word_i (mem_q[idx1_c]),
        .wdata1_i   (bus.writeData1),
        .wdata2_i   (bus.writeData2),
        .en1_i      (bus.laneEnable1),
        .en2_i      (bus.laneEnable2),
        .hit1_i     (wr1_c),
        .hit2_i     (wr2_c & same_c),
        .merged_c_o (post1_c)
    );

    lane_merge #(.DATA_WIDTH(DATA_WIDTH), .LANE_WIDTH(LANE_WIDTH)) u_merge2 (
        .old_word_i (mem_q[idx2_c]),
        .wdata1_i   (bus.writeData1),
        .wdata2_i   (bus.writeData2),
        .en1_i      (bus.laneEnable1),
        .en2_i      (bus.laneEnable2),
        .hit1_i     (wr1_c & same_c),
        .hit2_i     (wr2_c),
        .merged_c_o (post2_c)
    );

    // Storage array carries no reset; the clear sequencer zero-fills it instead.
    always_ff @(posedge clock) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr1_c) mem_q[idx1_c] <= post1_c;
            if (wr2_c) mem_q[idx2_c] <= post2_c;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            rvalid1_q <= 1'b0;
            rvalid2_q <= 1'b0;
            rerr1_q   <= 1'b0;
            rerr2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
            rvalid1_q <= rvalid1_d;
            rvalid2_q <= rvalid2_d;
            rerr1_q   <= rerr1_d;
            rerr2_q   <= rerr2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata1_d  = rdata1_q;
        rdata2_d  = rdata2_q;
        rvalid1_d = 1'b0;
        rvalid2_d = 1'b0;
        rerr1_d   = 1'b0;
        rerr2_d   = 1'b0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                // Any out-of-range request answers with a zero read and an error pulse.
                if ((bus.memoryRead1 | bus.memoryWrite1) & ~inr1_c) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = '0;
                    rerr1_d   = 1'b1;
                end else if (bus.memoryRead1) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = post1_c;
                end
                if ((bus.memoryRead2 | bus.memoryWrite2) & ~inr2_c) begin
                    rvalid2_d = 1'b1;
                    rdata2_d  = '0;
                    rerr2_d   = 1'b1;
                end else if (bus.memoryRead2) begin
                    rvalid2_d = 1'b1;
                    rdata2_d  = post2_c;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    assign bus.ready       = (state_q == READY);
    assign bus.readData1   = rdata1_q;
    assign bus.readData2   = rdata2_q;
    assign bus.readValid1  = rvalid1_q;
    assign bus.readValid2  = rvalid2_q;
    assign bus.rangeError1 = rerr1_q;
    assign bus.rangeError2 = rerr2_q;

endmodule

// File: tb/tb_dual_port_lane_memory.sv
// Bench for dual_port_lane_memory: clear sequencing, directed vector table,
// and randomized traffic against a lane-level reference model.
module tb_dual_port_lane_memory;

    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 16;
    localparam int unsigned NL    = 2;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 32;

    typedef struct {
        logic          w1, r1;
        logic [AW-1:0] a1;
        logic [NL-1:0] en1;
        logic [DW-1:0] d1;
        logic          w2, r2;
        logic [AW-1:0] a2;
        logic [NL-1:0] en2;
        logic [DW-1:0] d2;
    } req_t;

    typedef struct {
        req_t          q;
        logic          v1;
        logic [DW-1:0] x1;
        logic          e1;
        logic          v2;
        logic [DW-1:0] x2;
        logic          e2;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    dual_port_lane_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(NL)) bus ();

    dual_port_lane_memory #(
        .DATA_WIDTH(DW), .LANE_WIDTH(LW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock  (clk),
        .resetN (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: word array and the last value each read port returned.
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] mrd1, mrd2;
    logic          ev1, ev2, ee1, ee2;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic w1, input logic r1, input logic [AW-1:0] a1,
                                input logic [NL-1:0] en1, input logic [DW-1:0] d1,
                                input logic w2, input logic r2, input logic [AW-1:0] a2,
                                input logic [NL-1:0] en2, input logic [DW-1:0] d2);
        req_t r;
        r.w1 = w1; r.r1 = r1; r.a1 = a1; r.en1 = en1; r.d1 = d1;
        r.w2 = w2; r.r2 = r2; r.a2 = a2; r.en2 = en2; r.d2 = d2;
        return r;
    endfunction

    task automatic drive(input req_t r);
        bus.memoryWrite1 = r.w1; bus.memoryRead1 = r.r1; bus.address1 = r.a1;
        bus.laneEnable1  = r.en1; bus.writeData1 = r.d1;
        bus.memoryWrite2 = r.w2; bus.memoryRead2 = r.r2; bus.address2 = r.a2;
        bus.laneEnable2  = r.en2; bus.writeData2 = r.d2;
    endtask

    // Port 1 writes land first, port 2 second, so port 2 owns shared lanes; reads see the result.
    task automatic model_step(input req_t r);
        bit ok1, ok2;
        int i1, i2;
        ok1 = (r.a1 < AW'(DEPTH));
        ok2 = (r.a2 < AW'(DEPTH));
        i1  = ok1 ? int'(r.a1) : 0;
        i2  = ok2 ? int'(r.a2) : 0;
        if (r.w1 && ok1)
            for (int l = 0; l < NL; l++) if (r.en1[l]) mdl[i1][l*LW +: LW] = r.d1[l*LW +: LW];
        if (r.w2 && ok2)
            for (int l = 0; l < NL; l++) if (r.en2[l]) mdl[i2][l*LW +: LW] = r.d2[l*LW +: LW];
        ee1 = (r.r1 || r.w1) && !ok1;
        ee2 = (r.r2 || r.w2) && !ok2;
        ev1 = ee1 || r.r1;
        ev2 = ee2 || r.r2;
        if (ee1) mrd1 = '0; else if (r.r1) mrd1 = mdl[i1];
        if (ee2) mrd2 = '0; else if (r.r2) mrd2 = mdl[i2];
    endtask

    task automatic do_cycle(input req_t r, input string tag);
        drive(r);
        @(posedge clk);
        #1;
        model_step(r);
        chk({tag, ".valid1"}, DW'(bus.readValid1), DW'(ev1));
        chk({tag, ".data1"}, bus.readData1, mrd1);
        chk({tag, ".err1"}, DW'(bus.rangeError1), DW'(ee1));
        chk({tag, ".valid2"}, DW'(bus.readValid2), DW'(ev2));
        chk({tag, ".data2"}, bus.readData2, mrd2);
        chk({tag, ".err2"}, DW'(bus.rangeError2), DW'(ee2));
    endtask

    vec_t vec [12];
    req_t idle;
    req_t rq;
    int   n;

    initial begin
        idle = mk(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
        drive(idle);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", DW'(bus.ready), '0);
        chk("rst.valid1", DW'(bus.readValid1), '0);
        chk("rst.valid2", DW'(bus.readValid2), '0);
        chk("rst.data1", bus.readData1, '0);
        chk("rst.data2", bus.readData2, '0);
        chk("rst.err1", DW'(bus.rangeError1), '0);
        chk("rst.err2", DW'(bus.rangeError2), '0);

        // Start a clear, interrupt it after 10 cycles; requests meanwhile must be ignored.
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(mk(1, 1, AW'(c), 2'b11, 32'hFFFF_FFFF, 0, 1, AW'(40), '0, '0));
            @(posedge clk);
            #1;
            chk($sformatf("clr1.valid1[%0d]", c), DW'(bus.readValid1), '0);
            chk($sformatf("clr1.err2[%0d]", c), DW'(bus.rangeError2), '0);
            chk($sformatf("clr1.ready[%0d]", c), DW'(bus.ready), '0);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst.ready", DW'(bus.ready), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 100) begin
            drive(mk(1, $urandom_range(0, 1), AW'($urandom_range(0, 39)), 2'($urandom_range(0, 3)),
                     $urandom, 1, $urandom_range(0, 1), AW'($urandom_range(0, 39)),
                     2'($urandom_range(0, 3)), $urandom));
            @(posedge clk);
            #1;
            n++;
            if (bus.readValid1 || bus.readValid2 || bus.rangeError1 || bus.rangeError2) begin
                checks++;
                errors++;
                $display("FAIL clr2.response cycle=%0d actual=%b%b%b%b expected=0000", n,
                         bus.readValid1, bus.readValid2, bus.rangeError1, bus.rangeError2);
            end
        end
        chk("ready_latency", DW'(n), DW'(DEPTH));

        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        mrd1 = '0;
        mrd2 = '0;

        for (int i = 0; i < DEPTH; i++)
            do_cycle(mk(0, 1, AW'(i), '0, '0, 0, 1, AW'(DEPTH - 1 - i), '0, '0),
                     $sformatf("scan0[%0d]", i));

        vec[0]  = '{mk(1, 0, 5, 2'b10, 32'hAAAA_BBBB, 1, 0, 5, 2'b01, 32'h1111_2222),
                    0, 32'h0, 0, 0, 32'h0, 0};
        vec[1]  = '{mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0),
                    1, 32'hAAAA_2222, 0, 0, 32'h0, 0};
        vec[2]  = '{mk(1, 0, 7, 2'b11, 32'hDEAD_BEEF, 1, 0, 7, 2'b11, 32'h0123_4567),
                    0, 32'hAAAA_2222, 0, 0, 32'h0, 0};
        vec[3]  = '{mk(0, 1, 5, 0, 0, 0, 1, 7, 0, 0),
                    1, 32'hAAAA_2222, 0, 1, 32'h0123_4567, 0};
        vec[4]  = '{mk(1, 0, 3, 2'b11, 32'hCAFE_F00D, 0, 1, 3, 0, 0),
                    0, 32'hAAAA_2222, 0, 1, 32'hCAFE_F00D, 0};
        vec[5]  = '{mk(0, 1, 32, 0, 0, 1, 0, 40, 2'b11, 32'hFFFF_FFFF),
                    1, 32'h0, 1, 1, 32'h0, 1};
        vec[6]  = '{mk(1, 1, 9, 2'b01, 32'h1234_5678, 0, 1, 9, 0, 0),
                    1, 32'h0000_5678, 0, 1, 32'h0000_5678, 0};
        vec[7]  = '{mk(0, 1, 5, 0, 0, 1, 0, 5, 2'b00, 32'hFFFF_FFFF),
                    1, 32'hAAAA_2222, 0, 0, 32'h0000_5678, 0};
        vec[8]  = '{mk(0, 1, 32'h8000_0005, 0, 0, 0, 1, 5, 0, 0),
                    1, 32'h0, 1, 1, 32'hAAAA_2222, 0};
        vec[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    0, 32'h0, 0, 0, 32'hAAAA_2222, 0};
        vec[10] = '{mk(1, 0, 11, 2'b11, 32'h1111_5555, 1, 0, 11, 2'b10, 32'h2222_9999),
                    0, 32'h0, 0, 0, 32'hAAAA_2222, 0};
        vec[11] = '{mk(0, 1, 11, 0, 0, 0, 0, 0, 0, 0),
                    1, 32'h2222_5555, 0, 0, 32'hAAAA_2222, 0};

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].q);
            @(posedge clk);
            #1;
            model_step(vec[i].q);
            chk($sformatf("vec[%0d].valid1", i), DW'(bus.readValid1), DW'(vec[i].v1));
            chk($sformatf("vec[%0d].data1", i), bus.readData1, vec[i].x1);
            chk($sformatf("vec[%0d].err1", i), DW'(bus.rangeError1), DW'(vec[i].e1));
            chk($sformatf("vec[%0d].valid2", i), DW'(bus.readValid2), DW'(vec[i].v2));
            chk($sformatf("vec[%0d].data2", i), bus.readData2, vec[i].x2);
            chk($sformatf("vec[%0d].err2", i), DW'(bus.rangeError2), DW'(vec[i].e2));
        end

        // Out-of-range writes must have left every word untouched.
        for (int i = 0; i < DEPTH; i++)
            do_cycle(mk(0, 1, AW'(i), '0, '0, 0, 1, AW'(i), '0, '0), $sformatf("scan1[%0d]", i));

        for (int t = 0; t < 400; t++) begin
            rq = mk($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 39)),
                    2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 39)),
                    2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 3) == 0) rq.a2 = rq.a1;
            if ($urandom_range(0, 15) == 0) rq.a1 = rq.a1 | 32'h8000_0000;
            do_cycle(rq, $sformatf("rnd[%0d]", t));
        end
        chk("ready_hold", DW'(bus.ready), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_port_lane_memory.md
Name: dual_port_lane_memory

Overview:
- Parametrised successor to the pipeline's dual-port data memory.
- Two independent access ports, each able to read or write any lane subset of a DATA_WIDTH word through per-lane enables; no fixed half-word split per port.
- Features:
  - 1-cycle registered reads with valid strobes.
  - Write-first forwarding and deterministic per-lane collision resolution.
  - Out-of-range detection.
  - Post-reset clear sequencer that zeroes the array before accepting traffic.
- Sits in the MEM stage, serving two memory channels.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 16, lane granularity; LANES = DATA_WIDTH/LANE_WIDTH.
- DEPTH, 32, number of words; need not be a power of two.
- ADDR_WIDTH, 32, width of the address inputs (word addresses).
- CLEAR_ON_RESET, 1, when 1 the array is zero-filled after reset; when 0 the block is ready immediately.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- resetN  input  1  asynchronous, active-low reset.
- ready  output  1  high when requests are accepted (clear sequence done).
- memoryWrite1 / memoryWrite2  input  1  write request, port 1/2.
- memoryRead1 / memoryRead2  input  1  read request, port 1/2.
- address1 / address2  input  ADDR_WIDTH  word address, port 1/2.
- laneEnable1 / laneEnable2  input  LANES  per-lane write enable, port 1/2.
- writeData1 / writeData2  input  DATA_WIDTH  write data, port 1/2.
- readData1 / readData2  output  DATA_WIDTH  registered read data, port 1/2.
- readValid1 / readValid2  output  1  one-cycle pulse qualifying readDataN.
- rangeError1 / rangeError2  output  1  one-cycle pulse: request at address >= DEPTH.

Behaviour:
- Reset (resetN low, async):
  - readData* = 0, readValid* = 0, rangeError* = 0.
  - clear counter = 0.
  - FSM enters CLEAR when CLEAR_ON_RESET = 1, else READY; ready = 0 in CLEAR.
  - Array contents are not reset asynchronously.
- FSM:
  - CLEAR: each cycle write 0 to word[counter] and increment the counter. After writing word DEPTH-1 go to READY, so ready rises DEPTH cycles after resetN deasserts.
  - READY: terminal state until the next reset.
- Requests in CLEAR are ignored: no write, readValid = 0, rangeError = 0.
- Reset asserted mid-clear restarts the sequence from word 0.
- Write (READY, memoryWriteN = 1, addressN < DEPTH): on posedge, lane i of word[addressN] takes writeDataN lane i for every set laneEnableN[i]. Unenabled lanes are unchanged. laneEnable all zero is a no-op.
- Collision: both ports write the same word with overlapping lanes. Port 2 wins on overlapping lanes; non-overlapping lanes from both ports are applied.
- Read (READY, memoryReadN = 1, addressN < DEPTH):
  - readDataN = word[addressN] and readValidN = 1 in the cycle after the request edge (latency 1).
  - readDataN holds its value when no read occurs; readValidN = 0 otherwise.
- Read-during-write, same word, same edge, either port: write-first. Returned data is the post-write word, including collision resolution.
- Simultaneous read and write on one port are both honoured; the read returns the new data.
- Out of range (addressN >= DEPTH, any request): write dropped; readValidN = 1 with readDataN = 0; rangeErrorN pulses for one cycle aligned with readValidN (for writes, the cycle after the edge).
- Address width: addressN compared at full ADDR_WIDTH; no wrap-around or modulo aliasing.
- No debug $display.

Decomposition:
- Shared package mem_pkg:
  - LANES derivation function.
  - FSM state enum {CLEAR, READY}.
  - Helper computing a lane-merge mask.
- Natural sub-module: lane_merge. Combinational; given old word, two write words, two enable vectors and two hit flags, it produces the next word with port-2 priority. It is used both for the array update and for the write-first forwarding path.

Test Plan:
- Clear sequence: DEPTH=32, release resetN; ready rises exactly 32 cycles later. Then read every address -> readData = 0, readValid one cycle after each request.
- Lane write: port 1 writes 0xAAAA_BBBB to addr 5 with laneEnable = 2'b10, port 2 writes 0x1111_2222 to addr 5 with 2'b01 in the same cycle. Next read of addr 5 -> 0xAAAA_2222.
- Collision: both ports write addr 7, laneEnable = 2'b11, port 1 0xDEAD_BEEF, port 2 0x0123_4567 -> addr 7 reads 0x0123_4567.
- Write-first: addr 3 holds 0; port 1 writes 0xCAFE_F00D to addr 3 while port 2 reads addr 3 on the same edge -> readData2 = 0xCAFE_F00D, readValid2 = 1 next cycle.
- Range: port 1 reads addr 32 and port 2 writes addr 40 -> readData1 = 0, readValid1 = 1, rangeError1 = 1, rangeError2 = 1. A later scan shows all words unchanged.
- Mid-clear reset: assert resetN low at clear cycle 10; ready stays 0 and rises 32 cycles after the re-release. Requests issued during clear produce no readValid.
